// File: rtl/alu_exec_stage_if.sv
// ALU execute stage handshake bundle.
// Upstream op offer, downstream result and flush.
interface alu_exec_stage_if #(
  parameter int WIDTH = 64,
  parameter int RDW   = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [RDW-1:0]   in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RDW-1:0]   out_rd;
  logic             out_zero;
  logic             out_carry;
  logic             out_ovf;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_rd,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd,
    input  out_zero, out_carry, out_ovf, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_rd,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd,
    output out_zero, out_carry, out_ovf, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: combinational ALU feeding
// a two-entry skid buffer (OUT + SKID).
module alu_exec_stage #(
  parameter int WIDTH = 64,
  parameter int RDW   = 5
) (
  input logic         clk,
  input logic         rst,
  alu_exec_stage_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [RDW-1:0]   rd;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             illegal;
  } ent_t;

  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   sum, dif;
  logic [5:0]       sh;
  logic             cry, ovf, ill;
  logic             sa, sb;
  ent_t             new_e;
  ent_t             out_q, out_d;
  ent_t             skid_q, skid_d;
  logic             rdy_q;
  logic             drain, xfer;

  assign a   = bus.in_a;
  assign b   = bus.in_b;
  assign sh  = bus.in_b[5:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sa  = a[WIDTH-1];
  assign sb  = b[WIDTH-1];

  // ALU result and flags for the offered op
  always_comb begin
    res = '0;
    cry = 1'b0;
    ovf = 1'b0;
    ill = 1'b0;
    unique case (bus.in_op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a ^ b;
      4'd3: begin
        res = sum[WIDTH-1:0];
        cry = sum[WIDTH];
        ovf = (sa == sb) && (res[WIDTH-1] != sa);
      end
      4'd4: begin
        res = dif[WIDTH-1:0];
        cry = !dif[WIDTH];
        ovf = (sa != sb) && (res[WIDTH-1] != sa);
      end
      4'd5: res = {{(WIDTH-1){1'b0}},
                   $signed(a) < $signed(b)};
      4'd6: res = {{(WIDTH-1){1'b0}}, a < b};
      4'd7: res = a << sh;
      4'd8: res = a >> sh;
      4'd9: res = $unsigned($signed(a) >>> sh);
      4'd10: res = ~(a | b);
      4'd11: res = b;
      default: ill = 1'b1;
    endcase
  end

  // Pack the new entry; illegal ops report only the illegal flag
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.result  = res;
    new_e.rd      = bus.in_rd;
    new_e.zero    = !ill && (res == '0);
    new_e.carry   = cry;
    new_e.ovf     = ovf;
    new_e.illegal = ill;
  end

  assign drain = out_q.valid && bus.out_ready;
  assign xfer  = bus.in_valid && rdy_q;

  // Skid buffer next state; flush wins over everything
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (bus.flush) begin
      out_d  = '0;
      skid_d = '0;
    end else if (!out_q.valid || drain) begin
      if (skid_q.valid) begin
        out_d  = skid_q;
        skid_d = '0;
      end else if (xfer) begin
        out_d = new_e;
      end else begin
        out_d = '0;
      end
    end else if (xfer) begin
      skid_d = new_e;
    end
  end

  // Buffer registers; ready mirrors an empty SKID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      rdy_q  <= !skid_d.valid;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = out_q.valid;
  assign bus.out_result  = out_q.result;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_zero    = out_q.zero;
  assign bus.out_carry   = out_q.carry;
  assign bus.out_ovf     = out_q.ovf;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width of operands and result.
REQ-002 SHALL have parameter RDW, default 5, width of the destination register tag.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  upstream (ID/EX) offers an operation.
REQ-007 SHALL have port in_ready  output  1  stage can accept an operation this cycle.
REQ-008 SHALL have port in_op  input  4  operation code.
REQ-009 SHALL have ports in_a, in_b  input  WIDTH  operands.
REQ-010 SHALL have port in_rd  input  RDW  destination tag, carried through unchanged.
REQ-011 SHALL have port out_valid  output  1  result offered to EX/MEM.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports out_result  output  WIDTH, out_rd  output  RDW.
REQ-014 SHALL have ports out_zero, out_carry, out_ovf, out_illegal  output  1 each  result flags.

Function
REQ-015 SHALL compute by in_op: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB (A-B), 5 SLT signed, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 NOR, 11 PASS B; shift amount = in_b[5:0].
REQ-016 SHALL treat in_op 12-15 as illegal: result 0, out_illegal=1, other flags 0; entry still transfers normally.
REQ-017 SHALL set out_zero = (result==0) for every legal op.
REQ-018 SHALL set out_carry = carry-out for ADD, = 1 when A>=B unsigned (no borrow) for SUB, 0 otherwise.
REQ-019 SHALL set out_ovf = signed overflow for ADD/SUB, 0 otherwise; all arithmetic mod 2^WIDTH.
REQ-020 SHALL compute result and flags combinationally at input and capture them with the tag on transfer (in_valid && in_ready).
REQ-021 SHALL buffer in a 2-entry skid: output register (OUT) plus skid register (SKID); in_ready = !SKID.valid, driven from a register.
REQ-022 SHALL, on transfer with OUT empty or OUT draining (out_valid && out_ready), load OUT; latency one cycle, accepted op at edge N visible at out_* after edge N.
REQ-023 SHALL, on transfer with OUT held (out_valid && !out_ready), load SKID; when OUT drains, SKID moves to OUT and SKID empties.
REQ-024 SHALL sustain one op per cycle while out_ready=1 and preserve strict in-order delivery.
REQ-025 SHALL hold out_* stable while out_valid && !out_ready.
REQ-026 SHALL, on flush, empty OUT and SKID at the next edge and ignore in_valid that cycle; flush overrides simultaneous transfer and drain.
REQ-027 SHALL drive out_result/out_rd/flags to 0 whenever out_valid=0.

Reset
REQ-028 SHALL, on rst assertion, immediately clear OUT and SKID valid bits, data and flags: out_valid=0, in_ready=1, all other outputs 0.
REQ-029 SHALL discard any in-flight op on rst mid-operation and accept new ops the first edge after rst deasserts.

Verification
REQ-030 AND: A=AAAA_BBBB_CCCC_DDDD, B=1111_2222_3333_4444, op 0, out_ready=1 -> next cycle out_result=0000_2222_0000_4444, zero=0.
REQ-031 ADD overflow: A=7FFF_FFFF_FFFF_FFFF, B=1, op 3 -> result 8000_0000_0000_0000, ovf=1, carry=0; A=FFFF_FFFF_FFFF_FFFF, B=1 -> result 0, zero=1, carry=1, ovf=0.
REQ-032 Backpressure: out_ready=0, issue ops tag 1,2,3 back-to-back -> tag 1 in OUT, tag 2 in SKID, in_ready=0, tag 3 held upstream; raise out_ready -> tags 1,2,3 delivered in order on consecutive cycles.
REQ-033 Shifts/compare: A=8000_0000_0000_0000, B=4, SRA -> F800_0000_0000_0000; SRL -> 0800_0000_0000_0000; SLT A<B -> 1; SLTU -> 0.
REQ-034 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, issued op not captured; op 13 afterwards -> result 0, out_illegal=1.
REQ-035 Async rst asserted between edges with OUT valid -> out_valid falls immediately, in_ready=1, outputs 0.
